// File: rtl/mm_store_serializer.sv
// Purpose : splits one 32-bit store into little-endian single-byte writes on the byte-wide memory port.
// Latency : first byte in the cycle after acceptance; n bytes in n cycles with done on the last byte.
// Backpress: mem_stall holds the current byte/address and drops mem_wren; req_ready is low until idle.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             store request handshake
//   req_addr, req_data, req_size    byte address, store data, size (0 byte, 1 half, 2 word, 3 illegal)
//   mem_stall                       memory manager cannot take a write this cycle
//   mem_wdata, mem_waddr, mem_wren  byte write port
//   busy, done, err                 in progress, completion pulse, illegal-size pulse
module mm_store_serializer #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  input  logic              mem_stall,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        k_q;      // index of the byte currently presented
  logic [1:0]        last_q;   // index of the final byte (n-1)
  logic              accept;
  logic [1:0]        last_d;

  assign accept = req_valid & req_ready;

  always_comb begin
    last_d = 2'd3;
    case (req_size)
      2'd0:    last_d = 2'd0;
      2'd1:    last_d = 2'd1;
      default: last_d = 2'd3;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    busy      = 1'b0;
    mem_wren  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = (req_size == 2'd3) ? ERR : WRITE;
        end
      end
      WRITE: begin
        busy     = 1'b1;
        mem_wren = ~mem_stall;
        if (!mem_stall && (k_q == last_q)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      ERR: begin
        busy    = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are captured only on acceptance; the index advances on
  // every consumed byte except the last, so it stays put across stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      k_q    <= 2'd0;
      last_q <= 2'd0;
    end else if (accept) begin
      addr_q <= req_addr;
      data_q <= req_data;
      k_q    <= 2'd0;
      last_q <= last_d;
    end else if ((state_q == WRITE) && !mem_stall && (k_q != last_q)) begin
      k_q <= k_q + 2'd1;
    end
  end

  // Address addition is modulo 2^ADDR_W, so the top of memory wraps to 0.
  assign mem_wdata = data_q[{k_q, 3'b000} +: 8];
  assign mem_waddr = addr_q + ADDR_W'(k_q);

endmodule

// File: tb/tb_mm_store_serializer.sv
module tb_mm_store_serializer;

  localparam int ADDR_W = 19;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              mem_stall;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-1:0] mem_waddr;
  logic              mem_wren;
  logic              busy;
  logic              done;
  logic              err;

  int vec_cnt;
  int err_cnt;

  mm_store_serializer #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_stall (mem_stall),
    .mem_wdata (mem_wdata),
    .mem_waddr (mem_waddr),
    .mem_wren  (mem_wren),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Full port snapshot: {wren, waddr, wdata, done, err, busy, req_ready}
  function automatic logic [31:0] snap();
    return {mem_wren, mem_waddr, mem_wdata, done, err, busy, req_ready};
  endfunction

  function automatic logic [31:0] pack(input logic wr, input logic [ADDR_W-1:0] a,
                                       input logic [7:0] d, input logic dn, input logic er,
                                       input logic bs, input logic rd);
    return {wr, a, d, dn, er, bs, rd};
  endfunction

  // Control-only snapshot: {wren, done, err, busy, req_ready}
  function automatic logic [31:0] ctl();
    return {27'd0, mem_wren, done, err, busy, req_ready};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in the current (idle) cycle; returns 1 ns into cycle E+1.
  task automatic issue(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [1:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    step();
    req_valid = 1'b0;
    req_addr  = 19'h5A5A5;
    req_data  = 32'h99999999;
    req_size  = 2'd3;
  endtask

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = 2'd0;
    mem_stall = 1'b0;
    step();
    step();
    check("reset", snap(), pack(1'b0, 19'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    rst_n = 1'b1;
    step();
    check("idle0", ctl(), 32'b00001);

    // Word store
    issue(19'h00100, 32'hDEADBEEF, 2'd2);
    check("w_b0", snap(), pack(1'b1, 19'h00100, 8'hEF, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    check("w_b1", snap(), pack(1'b1, 19'h00101, 8'hBE, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    check("w_b2", snap(), pack(1'b1, 19'h00102, 8'hAD, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    check("w_b3", snap(), pack(1'b1, 19'h00103, 8'hDE, 1'b1, 1'b0, 1'b1, 1'b0));
    step();
    check("w_idle", ctl(), 32'b00001);

    // Byte store, then back-to-back halfword
    issue(19'h00010, 32'h12345678, 2'd0);
    check("b_b0", snap(), pack(1'b1, 19'h00010, 8'h78, 1'b1, 1'b0, 1'b1, 1'b0));
    step();
    check("b_idle", ctl(), 32'b00001);
    issue(19'h00011, 32'h12345678, 2'd1);
    check("h_b0", snap(), pack(1'b1, 19'h00011, 8'h78, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    check("h_b1", snap(), pack(1'b1, 19'h00012, 8'h56, 1'b1, 1'b0, 1'b1, 1'b0));
    step();
    check("h_idle", ctl(), 32'b00001);

    // Address wrap
    issue(19'h7FFFE, 32'hA1B2C3D4, 2'd2);
    check("wr_b0", snap(), pack(1'b1, 19'h7FFFE, 8'hD4, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    check("wr_b1", snap(), pack(1'b1, 19'h7FFFF, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    check("wr_b2", snap(), pack(1'b1, 19'h00000, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    check("wr_b3", snap(), pack(1'b1, 19'h00001, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b0));
    step();
    check("wr_idle", ctl(), 32'b00001);

    // Two stall cycles on byte 1; done lands in E+6
    issue(19'h00200, 32'h11223344, 2'd2);
    check("s_b0", snap(), pack(1'b1, 19'h00200, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    mem_stall = 1'b1;
    #1;
    check("s_st0", snap(), pack(1'b0, 19'h00201, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    check("s_st1", snap(), pack(1'b0, 19'h00201, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    mem_stall = 1'b0;
    #1;
    check("s_b1", snap(), pack(1'b1, 19'h00201, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    check("s_b2", snap(), pack(1'b1, 19'h00202, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    check("s_b3", snap(), pack(1'b1, 19'h00203, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0));
    step();
    check("s_idle", ctl(), 32'b00001);

    // Illegal size
    issue(19'h00300, 32'h55667788, 2'd3);
    check("e_err", ctl(), 32'b00110);
    step();
    check("e_idle", ctl(), 32'b00001);

    // Reset in the middle of a word store
    issue(19'h00400, 32'hCAFEF00D, 2'd2);
    check("r_b0", snap(), pack(1'b1, 19'h00400, 8'h0D, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    check("r_b1", snap(), pack(1'b1, 19'h00401, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0));
    rst_n = 1'b0;
    #1;
    check("r_rst", snap(), pack(1'b0, 19'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    #1;
    rst_n = 1'b1;
    step();
    check("r_hold", ctl(), 32'b00001);
    issue(19'h00010, 32'h0000BEEF, 2'd1);
    check("r2_b0", snap(), pack(1'b1, 19'h00010, 8'hEF, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    check("r2_b1", snap(), pack(1'b1, 19'h00011, 8'hBE, 1'b1, 1'b0, 1'b1, 1'b0));
    step();
    check("r2_idle", ctl(), 32'b00001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
